// File: rtl/tick_pkg.sv
// Shared types and constants for the tick scheduler.
package tick_pkg;

    localparam int unsigned CPU_CLOCK = 27_000_000;

    // Widest channel index and period the pending slot can hold.
    localparam int unsigned MAX_CH_W = 3;
    localparam int unsigned MAX_PW   = 32;

    typedef enum logic {
        StIdle,
        StRun
    } ch_state_e;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic [MAX_PW-1:0]   period;
        logic                oneshot;
        logic                enable;
    } cfg_t;

endpackage

// File: rtl/tick_prescaler.sv
// Shared prescaler: base_tick is high for one cycle in every CLK_HZ/TICK_HZ.
module tick_prescaler
    import tick_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CPU_CLOCK,
    parameter int unsigned TICK_HZ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic base_tick
);

    localparam int unsigned PRESC = CLK_HZ / TICK_HZ;
    localparam int unsigned CW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    if (PRESC < 2) begin : g_bad_presc
        $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    assign base_tick = (cnt_q == CW'(PRESC - 1));

    // Count 0..PRESC-1 and wrap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (base_tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel periodic/one-shot tick generator sharing one prescaler.
// A single pending configuration slot is applied on the next base tick.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CPU_CLOCK,
    parameter int unsigned TICK_HZ = 1_000,
    parameter int unsigned NCH     = 4,
    parameter int unsigned PW      = 16,
    localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    input  logic           cfg_oneshot,
    input  logic           cfg_enable,
    output logic [NCH-1:0] tick_out,
    output logic [NCH-1:0] toggle_out,
    output logic [NCH-1:0] busy
);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("tick_scheduler: NCH must be in 1..8");
    end
    if (PW < 1 || PW > MAX_PW) begin : g_bad_pw
        $error("tick_scheduler: PW out of range");
    end

    logic base_tick;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_tick (base_tick)
    );

    cfg_t pend_q, pend_d;
    logic pend_valid_q, pend_valid_d;
    logic apply;

    assign cfg_ready = ~pend_valid_q;
    assign apply     = base_tick & pend_valid_q;

    // Upper period bits of the slot exist only for the widest configuration.
    logic unused_pend_bits;
    assign unused_pend_bits = ^pend_q.period;

    // Pending slot: capture on handshake, release on the applying base tick.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end else if (cfg_valid && cfg_ready) begin
            pend_valid_d   = 1'b1;
            pend_d.ch      = MAX_CH_W'(cfg_ch);
            pend_d.period  = MAX_PW'(cfg_period);
            pend_d.oneshot = cfg_oneshot;
            pend_d.enable  = cfg_enable;
        end
    end

    // Pending slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e     state_q, state_d;
        logic [PW-1:0] count_q, count_d;
        logic [PW-1:0] period_q, period_d;
        logic          oneshot_q, oneshot_d;
        logic          tick_q, tick_d;
        logic          toggle_q, toggle_d;
        logic          apply_ch;
        logic [PW-1:0] new_period;

        assign apply_ch   = apply && (pend_q.ch == MAX_CH_W'(i));
        assign new_period = pend_q.period[PW-1:0];

        // Channel next state: an apply overrides any expiry on the same tick.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            period_d  = period_q;
            oneshot_d = oneshot_q;
            tick_d    = 1'b0;
            toggle_d  = toggle_q;
            if (apply_ch) begin
                if (pend_q.enable && (new_period != '0)) begin
                    state_d   = StRun;
                    count_d   = new_period - 1'b1;
                    period_d  = new_period;
                    oneshot_d = pend_q.oneshot;
                end else begin
                    state_d = StIdle;
                end
            end else if (base_tick && (state_q == StRun)) begin
                if (count_q == '0) begin
                    tick_d   = 1'b1;
                    toggle_d = ~toggle_q;
                    if (oneshot_q) begin
                        state_d = StIdle;
                    end else begin
                        count_d = period_q - 1'b1;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= StIdle;
                count_q   <= '0;
                period_q  <= '0;
                oneshot_q <= 1'b0;
                tick_q    <= 1'b0;
                toggle_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                period_q  <= period_d;
                oneshot_q <= oneshot_d;
                tick_q    <= tick_d;
                toggle_q  <= toggle_d;
            end
        end

        assign tick_out[i]   = tick_q;
        assign toggle_out[i] = toggle_q;
        assign busy[i]       = (state_q == StRun);
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel periodic/one-shot tick generator; all channels share one prescaler divider.
- Replaces per-consumer free-running clock dividers: UI blink, debounce sampling, slow CPU step clock.
- Software or FSM masters configure channels through a valid/ready port.
- Each channel drives a one-cycle tick pulse and a 50%-duty toggle line.

Parameters:
- CLK_HZ, 27_000_000, board input clock frequency.
- TICK_HZ, 1_000, base tick rate of the shared prescaler.
- NCH, 4, number of channels (1..8).
- PW, 16, channel period width in base ticks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  scheduler can accept a configuration.
- cfg_ch  in  $clog2(NCH)  target channel.
- cfg_period  in  PW  period in base ticks; 0 means disable.
- cfg_oneshot  in  1  1 = fire once, then idle; 0 = periodic.
- cfg_enable  in  1  1 = start/restart channel; 0 = stop channel.
- tick_out  out  NCH  one-cycle pulse per channel expiry.
- toggle_out  out  NCH  inverts on each expiry.
- busy  out  NCH  channel is in RUN.

Behaviour:
- PRESC = CLK_HZ/TICK_HZ. Elaboration error if PRESC < 2.
- Prescaler:
  - Counter runs 0..PRESC-1, then wraps to 0.
  - base_tick is combinational, high while the counter equals PRESC-1; one cycle in every PRESC.
- Reset (async assert, sync-safe deassert):
  - Prescaler = 0; all channels IDLE.
  - tick_out = 0, toggle_out = 0, busy = 0.
  - Pending configuration cleared; cfg_ready = 1.
  - Reset mid-operation discards everything, with no glitch pulse on tick_out.
- Config handshake:
  - A transfer occurs on a rising edge with cfg_valid & cfg_ready.
  - The fields are latched into one pending slot; cfg_ready goes low the next cycle.
  - The pending entry is applied at the next edge where base_tick = 1; cfg_ready returns high on the following cycle.
  - Worst-case accept-to-apply latency is PRESC cycles.
  - While cfg_ready = 0, cfg_valid is ignored; the master holds it.
- Apply rules:
  - If cfg_enable = 1 and cfg_period != 0: channel enters RUN, count = cfg_period-1, mode latched, busy = 1.
  - Otherwise: channel goes IDLE, busy = 0; toggle_out holds its value.
- Channel FSM, per channel:
  - IDLE -> RUN on apply with enable.
  - RUN -> RUN on a base_tick with count > 0: decrement.
  - RUN expiry (base_tick with count == 0):
    - tick_out[ch] = 1 for exactly one cycle, registered on that edge.
    - toggle_out[ch] inverts.
    - Periodic: reload count = period-1 and stay in RUN.
    - One-shot: go to IDLE, busy = 0.
  - RUN -> IDLE on apply with disable.
- Timing consequences:
  - Period P gives ticks spaced exactly P*PRESC cycles.
  - First tick comes P*PRESC cycles after the apply edge.
- Simultaneous events:
  - Apply and expiry on the same base_tick for the same channel: apply wins, no tick_out that tick.
  - Other channels decrement or expire normally on that tick.
- Wrap-around: count never underflows. Period 2^PW-1 is legal; period 1 ticks every base_tick.

Decomposition:
- Package tick_pkg:
  - CPU_CLOCK = 27_000_000.
  - Channel state enum {IDLE, RUN}.
  - cfg_t struct {ch, period, oneshot, enable}.
- Sub-module tick_prescaler:
  - Parameters CLK_HZ, TICK_HZ.
  - Ports clk, rst_n, base_tick.
- Channels are a generate loop in tick_scheduler.

Test Plan (CLK_HZ=20, TICK_HZ=2 -> PRESC=10, NCH=4, PW=8):
- Reset: hold rst_n=0 for 3 cycles -> tick_out=0, toggle_out=0, busy=0, cfg_ready=1. First base_tick at cycle 10 after release.
- Periodic: ch0, period 3, oneshot 0, enable 1 -> busy[0]=1 at apply. tick_out[0] pulses every 30 cycles, each 1 cycle wide; toggle_out[0] goes 1,0,1 on the first three expiries.
- One-shot: ch2, period 1, oneshot 1 -> exactly one tick_out[2] pulse 10 cycles after apply, then busy[2]=0 and toggle_out[2] stays 1 forever.
- Handshake back-pressure: two back-to-back writes (ch1 then ch3) -> cfg_ready low after the first transfer. Second write accepted only after ch1 is applied; ch3 applied at the following base_tick, 10 cycles later.
- Apply/expiry collision: ch0 running period 2; rewrite ch0 with period 5 timed so apply coincides with its expiry -> no tick_out[0] that tick. Next pulse 50 cycles later; ch1 ticks unaffected.
- Disable and async reset mid-run: write ch0 enable=0 -> busy[0]=0, toggle_out[0] frozen, no further ticks. Assert rst_n mid-pending-write -> cfg_ready=1 and all outputs 0 immediately; pending write never applied.
